parse_is_attacked: RTL and testbench

Receive-side counterpart of the attacked-square text display. It consumes an ASCII character stream, one byte per handshake, and rebuilds a 64-bit attacked bitboard from it. The stream is eight text lines of eight square characters, rank 7 first, file 0 leftmost. The block sits between a character source (UART receiver or testbench feeder) and any logic that consumes a 64-bit attacked/occupancy mask.

---
 rtl/parse_is_attacked.sv | 125 ++++++++++++
 tb/tb_parse_is_attacked.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/parse_is_attacked.sv
// Rebuilds a 64-bit attacked bitboard from an ASCII stream of eight lines of
// eight 'X'/'.' characters. Rank 7 arrives first and file 0 is leftmost.
module parse_is_attacked (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [63:0] attacked,
  output logic        attacked_valid,
  output logic        parse_error
);

  localparam logic [7:0] MARK_CHAR  = 8'h58;  // 'X'
  localparam logic [7:0] EMPTY_CHAR = 8'h2E;  // '.'
  localparam logic [7:0] CR_CHAR    = 8'h0D;
  localparam logic [7:0] LF_CHAR    = 8'h0A;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_SQUARE = 2'd1,
    S_EOL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_shadow;
  logic [63:0] r_attacked;
  logic [5:0]  r_index;
  logic [5:0]  r_row_start;
  logic [2:0]  r_col;
  logic        r_char_ready;
  logic        r_attacked_valid;
  logic        r_parse_error;

  logic w_hs;
  logic w_is_square;

  assign w_hs        = char_valid & r_char_ready;
  assign w_is_square = (char_in == MARK_CHAR) || (char_in == EMPTY_CHAR);

  // NOTE: the shadow board is reset together with the control state, so a
  // board interrupted by reset can never leak bits into the next one.
  // NOTE: every assignment below is non-blocking so all registers update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_INIT;
      r_shadow         <= '0;
      r_attacked       <= '0;
      r_index          <= '0;
      r_row_start      <= '0;
      r_col            <= '0;
      r_char_ready     <= 1'b0;
      r_attacked_valid <= 1'b0;
      r_parse_error    <= 1'b0;
    end else begin
      r_attacked_valid <= 1'b0;
      r_parse_error    <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_row_start  <= 6'd56;
          r_index      <= 6'd56;
          r_col        <= 3'd0;
          r_shadow     <= '0;
          r_char_ready <= 1'b1;
          r_state      <= S_SQUARE;
        end
        S_SQUARE: begin
          if (w_hs) begin
            if (w_is_square) begin
              r_shadow[r_index] <= (char_in == MARK_CHAR);
              r_index           <= r_index + 6'd1;
              if (r_col == 3'd7) begin
                r_state <= S_EOL;
              end else begin
                r_col <= r_col + 3'd1;
              end
            end else if (char_in != CR_CHAR) begin
              r_parse_error <= 1'b1;
              r_char_ready  <= 1'b0;
              r_state       <= S_INIT;
            end
          end
        end
        S_EOL: begin
          if (w_hs) begin
            if (char_in == LF_CHAR) begin
              if (r_row_start != 6'd0) begin
                r_row_start <= r_row_start - 6'd8;
                r_index     <= r_row_start - 6'd8;
                r_col       <= 3'd0;
                r_state     <= S_SQUARE;
              end else begin
                // Only a fully parsed board is ever published.
                r_attacked       <= r_shadow;
                r_attacked_valid <= 1'b1;
                r_char_ready     <= 1'b0;
                r_state          <= S_DONE;
              end
            end else if (char_in != CR_CHAR) begin
              r_parse_error <= 1'b1;
              r_char_ready  <= 1'b0;
              r_state       <= S_INIT;
            end
          end
        end
        S_DONE: begin
          r_char_ready <= 1'b0;
          r_state      <= S_INIT;
        end
        default: begin
          r_char_ready <= 1'b0;
          r_state      <= S_INIT;
        end
      endcase
    end
  end

  assign char_ready     = r_char_ready;
  assign attacked       = r_attacked;
  assign attacked_valid = r_attacked_valid;
  assign parse_error    = r_parse_error;

endmodule

// File: tb/tb_parse_is_attacked.sv
// Directed and randomized stimulus for parse_is_attacked; expected boards come
// from a rank/file model of the text format kept in this bench.
module tb_parse_is_attacked;

  localparam logic [7:0] C_X   = 8'h58;
  localparam logic [7:0] C_DOT = 8'h2E;
  localparam logic [7:0] C_CR  = 8'h0D;
  localparam logic [7:0] C_LF  = 8'h0A;
  localparam logic [7:0] C_Q   = 8'h51;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [63:0] attacked;
  logic        attacked_valid;
  logic        parse_error;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid_pulses = 0;
  int n_err_pulses = 0;
  int cyc = 0;
  logic [63:0] last_board = 64'h0;
  logic [7:0]  stream[$];

  parse_is_attacked dut (
    .clk            (clk),
    .reset          (reset),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .attacked       (attacked),
    .attacked_valid (attacked_valid),
    .parse_error    (parse_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      if (attacked_valid) n_valid_pulses++;
      if (parse_error)    n_err_pulses++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Text image of a board: rank 7 first, file 0 leftmost, bit = rank*8+file.
  task automatic build(input logic [63:0] b, input bit crlf, input bit sprinkle_cr);
    stream.delete();
    for (int r = 7; r >= 0; r--) begin
      for (int f = 0; f < 8; f++) begin
        if (sprinkle_cr && ($urandom_range(3, 0) == 0)) stream.push_back(C_CR);
        stream.push_back(b[r*8+f] ? C_X : C_DOT);
      end
      if (crlf) stream.push_back(C_CR);
      stream.push_back(C_LF);
    end
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (char_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check({tag, "_ready_timeout"}, 64'(char_ready), 64'd1);
  endtask

  // Present a byte and hold it until the handshake edge; returns on the
  // falling edge after that handshake.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      char_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    char_in    = b;
    char_valid = 1'b1;
    wait_ready("hs");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_board(input logic [63:0] b, input bit crlf, input int maxgap,
                            input bit sprinkle, input string tag);
    int v0;
    int e0;
    build(b, crlf, sprinkle);
    v0 = n_valid_pulses;
    e0 = n_err_pulses;
    foreach (stream[i]) send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    char_valid = 1'b0;
    check({tag, "_valid_pulse"}, 64'(attacked_valid), 64'd1);
    check({tag, "_board"}, attacked, b);
    check({tag, "_ready_done"}, 64'(char_ready), 64'd0);
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(attacked_valid), 64'd0);
    check({tag, "_ready_init"}, 64'(char_ready), 64'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 64'(char_ready), 64'd1);
    check({tag, "_valid_count"}, 64'(n_valid_pulses - v0), 64'd1);
    check({tag, "_err_count"}, 64'(n_err_pulses - e0), 64'd0);
    last_board = b;
  endtask

  // Sends the first n bytes of the current stream, then the offending byte.
  task automatic send_error(input int n, input logic [7:0] bad, input string tag);
    int v0;
    int e0;
    v0 = n_valid_pulses;
    e0 = n_err_pulses;
    for (int i = 0; i < n; i++) send_byte(stream[i], 0);
    send_byte(bad, 0);
    char_valid = 1'b0;
    check({tag, "_err_pulse"}, 64'(parse_error), 64'd1);
    check({tag, "_ready_err"}, 64'(char_ready), 64'd0);
    check({tag, "_board_held"}, attacked, last_board);
    @(negedge clk);
    check({tag, "_err_drop"}, 64'(parse_error), 64'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 64'(char_ready), 64'd1);
    check({tag, "_err_count"}, 64'(n_err_pulses - e0), 64'd1);
    check({tag, "_valid_count"}, 64'(n_valid_pulses - v0), 64'd0);
  endtask

  initial begin
    int c0;
    int v0;
    int e0;
    logic [63:0] rnd;

    #1;
    check("rst_attacked", attacked, 64'h0);
    check("rst_ready", 64'(char_ready), 64'd0);
    check("rst_valid", 64'(attacked_valid), 64'd0);
    check("rst_err", 64'(parse_error), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("init_ready_low", 64'(char_ready), 64'd0);
    @(negedge clk);
    check("init_ready_high", 64'(char_ready), 64'd1);

    // Empty board back to back; next board may start 74 cycles after ready.
    c0 = cyc;
    send_board(64'h0, 1'b0, 0, 1'b0, "empty");
    check("empty_period", 64'(cyc - c0), 64'd74);

    send_board(64'h0100_0000_0000_0080, 1'b0, 0, 1'b0, "corners");
    send_board(64'h0100_0000_0000_0080, 1'b1, 5, 1'b1, "corners_crlf");

    build(64'h0, 1'b0, 1'b0);
    send_error(19, C_Q, "q20");
    send_board(64'h0000_0000_FF00_0000, 1'b0, 0, 1'b0, "rank3");

    build(64'h0, 1'b0, 1'b0);
    send_error(8, C_X, "ninth");
    send_board(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, "all_x");

    build(64'h0, 1'b0, 1'b0);
    send_error(3, C_LF, "early_lf");

    // Reset in the middle of a board.
    build(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    v0 = n_valid_pulses;
    e0 = n_err_pulses;
    for (int i = 0; i < 40; i++) send_byte(stream[i], 0);
    char_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_attacked", attacked, 64'h0);
    check("mid_rst_ready", 64'(char_ready), 64'd0);
    check("mid_rst_valid", 64'(attacked_valid), 64'd0);
    check("mid_rst_err", 64'(parse_error), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_init", 64'(char_ready), 64'd0);
    @(negedge clk);
    check("mid_rst_no_pulses", 64'((n_valid_pulses - v0) + (n_err_pulses - e0)), 64'd0);
    last_board = 64'h0;
    send_board(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, "after_rst");

    // Random boards with random line endings, stray CRs and stalls.
    for (int k = 0; k < 4; k++) begin
      rnd = {$urandom, $urandom};
      send_board(rnd, 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)),
                 1'($urandom_range(1, 0)), $sformatf("rand%0d", k));
    end

    // A long stall before the next board changes nothing.
    repeat (30) @(negedge clk);
    check("idle_hold", attacked, last_board);
    check("idle_ready", 64'(char_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
